// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_ctrl
// Purpose  : Multicycle CPU control FSM with a memory-stall watchdog.
//            Optional macro ILLEGAL_TRAP_EN makes unknown opcodes halt.
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_ctrl #(
  parameter int unsigned STALL_MAX = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       iord,
  output logic       ir_we,
  output logic       pc_we,
  output logic       branch,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] aluop,
  output logic       reg_we,
  output logic       wb_sel,
  output logic [3:0] state,
  output logic       fault,
  output logic       illegal
);

  typedef enum logic [3:0] {
    ST_FETCH  = 4'd0, ST_DECODE = 4'd1, ST_ADDR   = 4'd2,
    ST_MEM    = 4'd3, ST_WB_MEM = 4'd4, ST_EXEC_R = 4'd5,
    ST_WB_ALU = 4'd6, ST_BRANCH = 4'd7, ST_HALT   = 4'd8
  } state_t;

  typedef enum logic [2:0] {
    CLS_NONE = 3'd0, CLS_R = 3'd1, CLS_LOAD = 3'd2,
    CLS_STORE = 3'd3, CLS_BRANCH = 3'd4
  } cls_t;

  localparam logic [7:0] STALL_LIM = 8'(STALL_MAX);
  localparam logic       STALL_EN  = (STALL_MAX != 0);

  state_t     state_q, state_d;
  cls_t       cls_q, cls_d;
  logic [7:0] stall_q, stall_d, stall_inc;
  logic       fault_q, fault_d;
  logic       stall_hit;
  logic       mem_req_raw, ir_we_raw, pc_we_raw;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_FETCH;
      cls_q   <= CLS_NONE;
      stall_q <= 8'd0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      stall_q <= stall_d;
      fault_q <= fault_d;
    end
  end

`ifdef ILLEGAL_TRAP_EN
  logic illegal_q, illegal_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) illegal_q <= 1'b0;
    else        illegal_q <= illegal_d;
  end

  assign illegal = illegal_q;
`else
  assign illegal = 1'b0;
`endif

  // Saturating so a disabled watchdog never wraps back through small values.
  assign stall_inc = (stall_q == 8'hFF) ? stall_q : stall_q + 8'd1;
  assign stall_hit = STALL_EN && (stall_inc == STALL_LIM);

  always_comb begin
    state_d     = state_q;
    cls_d       = cls_q;
    fault_d     = fault_q;
`ifdef ILLEGAL_TRAP_EN
    illegal_d   = illegal_q;
`endif
    mem_req_raw = 1'b0;
    mem_we      = 1'b0;
    iord        = 1'b0;
    ir_we_raw   = 1'b0;
    pc_we_raw   = 1'b0;
    branch      = 1'b0;
    alusrca     = 1'b0;
    alusrcb     = 2'b00;
    aluop       = 2'b00;
    reg_we      = 1'b0;
    wb_sel      = 1'b0;

    case (state_q)
      ST_FETCH: begin
        mem_req_raw = 1'b1;
        alusrcb     = 2'b01;
        if (mem_ready) begin
          ir_we_raw = 1'b1;
          pc_we_raw = 1'b1;
          state_d   = ST_DECODE;
        end else if (stall_hit) begin
          state_d = ST_HALT;
          fault_d = 1'b1;
        end
      end
      ST_DECODE: begin
        case (opcode)
          7'b0110011: begin cls_d = CLS_R;      state_d = ST_EXEC_R; end
          7'b0000011: begin cls_d = CLS_LOAD;   state_d = ST_ADDR;   end
          7'b0100011: begin cls_d = CLS_STORE;  state_d = ST_ADDR;   end
          7'b1100011: begin cls_d = CLS_BRANCH; state_d = ST_BRANCH; end
          default: begin
            cls_d = CLS_NONE;
`ifdef ILLEGAL_TRAP_EN
            state_d   = ST_HALT;
            illegal_d = 1'b1;
`else
            state_d   = ST_FETCH;
`endif
          end
        endcase
      end
      ST_ADDR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = ST_MEM;
      end
      ST_MEM: begin
        mem_req_raw = 1'b1;
        iord        = 1'b1;
        mem_we      = (cls_q == CLS_STORE);
        if (mem_ready) begin
          state_d = (cls_q == CLS_STORE) ? ST_FETCH : ST_WB_MEM;
        end else if (stall_hit) begin
          state_d = ST_HALT;
          fault_d = 1'b1;
        end
      end
      ST_WB_MEM: begin
        reg_we  = 1'b1;
        wb_sel  = 1'b1;
        state_d = ST_FETCH;
      end
      ST_EXEC_R: begin
        alusrca = 1'b1;
        aluop   = 2'b10;
        state_d = ST_WB_ALU;
      end
      ST_WB_ALU: begin
        reg_we  = 1'b1;
        state_d = ST_FETCH;
      end
      ST_BRANCH: begin
        alusrca = 1'b1;
        aluop   = 2'b01;
        branch  = 1'b1;
        state_d = ST_FETCH;
      end
      ST_HALT: ;
      default: state_d = ST_FETCH;
    endcase
  end

  // Counter only survives while waiting in place; any state change clears it.
  always_comb begin
    stall_d = 8'd0;
    if ((state_q == ST_FETCH || state_q == ST_MEM) && !mem_ready && state_d == state_q)
      stall_d = stall_inc;
  end

  // No request or strobe may leave the block while reset is held.
  assign mem_req = mem_req_raw & rst_n;
  assign ir_we   = ir_we_raw & rst_n;
  assign pc_we   = pc_we_raw & rst_n;
  assign state   = state_q;
  assign fault   = fault_q;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_ctrl
// Purpose  : Scoreboard bench for multicycle_ctrl (STALL_MAX = 4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_ctrl;

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_LD = 7'b0000011;
    localparam logic [6:0] OP_ST = 7'b0100011;
    localparam logic [6:0] OP_BR = 7'b1100011;
    localparam logic [6:0] OP_IL = 7'b1111111;

    // {state, mem_req mem_we iord ir_we pc_we branch alusrca, alusrcb, aluop, reg_we wb_sel fault illegal}
    localparam logic [18:0] E_RST     = {4'd0, 7'b0000000, 2'b01, 2'b00, 4'b0000};
    localparam logic [18:0] E_FETCH_W = {4'd0, 7'b1000000, 2'b01, 2'b00, 4'b0000};
    localparam logic [18:0] E_FETCH_G = {4'd0, 7'b1001100, 2'b01, 2'b00, 4'b0000};
    localparam logic [18:0] E_DECODE  = {4'd1, 7'b0000000, 2'b00, 2'b00, 4'b0000};
    localparam logic [18:0] E_ADDR    = {4'd2, 7'b0000001, 2'b10, 2'b00, 4'b0000};
    localparam logic [18:0] E_MEM_LD  = {4'd3, 7'b1010000, 2'b00, 2'b00, 4'b0000};
    localparam logic [18:0] E_MEM_ST  = {4'd3, 7'b1110000, 2'b00, 2'b00, 4'b0000};
    localparam logic [18:0] E_WB_MEM  = {4'd4, 7'b0000000, 2'b00, 2'b00, 4'b1100};
    localparam logic [18:0] E_EXEC_R  = {4'd5, 7'b0000001, 2'b00, 2'b10, 4'b0000};
    localparam logic [18:0] E_WB_ALU  = {4'd6, 7'b0000000, 2'b00, 2'b00, 4'b1000};
    localparam logic [18:0] E_BRANCH  = {4'd7, 7'b0000011, 2'b00, 2'b01, 4'b0000};
    localparam logic [18:0] E_HALT_F  = {4'd8, 7'b0000000, 2'b00, 2'b00, 4'b0010};
`ifdef ILLEGAL_TRAP_EN
    localparam logic [18:0] E_HALT_I  = {4'd8, 7'b0000000, 2'b00, 2'b00, 4'b0001};
`endif

    typedef struct {
        string       name;
        logic [18:0] vec;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] opcode;
    logic       mem_ready;
    logic       mem_req, mem_we, iord, ir_we, pc_we, branch, alusrca;
    logic [1:0] alusrcb, aluop;
    logic       reg_we, wb_sel, fault, illegal;
    logic [3:0] state;
    logic [18:0] obs;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    multicycle_ctrl #(.STALL_MAX(4)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_we(ir_we),
        .pc_we(pc_we), .branch(branch), .alusrca(alusrca), .alusrcb(alusrcb),
        .aluop(aluop), .reg_we(reg_we), .wb_sel(wb_sel), .state(state),
        .fault(fault), .illegal(illegal)
    );

    always #5 clk = ~clk;

    assign obs = {state, mem_req, mem_we, iord, ir_we, pc_we, branch, alusrca,
                  alusrcb, aluop, reg_we, wb_sel, fault, illegal};

    // Monitor: samples after each falling clock and after an asynchronous reset assertion.
    always @(negedge clk or negedge rst_n) begin
        #1;
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            checks++;
            if (obs !== e.vec) begin
                errors++;
                $display("FAIL %s: got %05h required %05h (t=%0t)", e.name, obs, e.vec, $time);
            end
        end
    end

    task automatic check_now(input logic [18:0] e, input string nm);
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL %s: got %05h required %05h (t=%0t)", nm, obs, e, $time);
        end
    endtask

    task automatic step(input logic rv, input logic [6:0] op, input logic rdy,
                        input logic [18:0] e, input string nm);
        exp_t ent;
        @(posedge clk);
        #1;
        rst_n     = rv;
        opcode    = op;
        mem_ready = rdy;
        ent.name  = nm;
        ent.vec   = e;
        q.push_back(ent);
    endtask

    initial begin
        exp_t ent;
        rst_n = 1'b0; opcode = 7'd0; mem_ready = 1'b1;

        // Reset state: FETCH values but no strobes/request, even with mem_ready high
        step(1'b0, OP_R, 1'b1, E_RST, "reset0");
        step(1'b0, OP_R, 1'b1, E_RST, "reset1");
        check_now(E_RST, "reset_direct");

        // R-type: 4 cycles
        step(1'b1, OP_R, 1'b1, E_FETCH_G, "r_fetch");
        step(1'b1, OP_R, 1'b1, E_DECODE,  "r_decode");
        step(1'b1, OP_R, 1'b1, E_EXEC_R,  "r_exec");
        step(1'b1, OP_R, 1'b1, E_WB_ALU,  "r_wb");

        // Load with 3 wait cycles in MEM: 8 cycles
        step(1'b1, OP_LD, 1'b1, E_FETCH_G, "ld_fetch");
        step(1'b1, OP_LD, 1'b1, E_DECODE,  "ld_decode");
        step(1'b1, OP_LD, 1'b1, E_ADDR,    "ld_addr");
        step(1'b1, OP_LD, 1'b0, E_MEM_LD,  "ld_mem_w1");
        step(1'b1, OP_LD, 1'b0, E_MEM_LD,  "ld_mem_w2");
        step(1'b1, OP_LD, 1'b0, E_MEM_LD,  "ld_mem_w3");
        step(1'b1, OP_LD, 1'b1, E_MEM_LD,  "ld_mem_go");
        step(1'b1, OP_LD, 1'b1, E_WB_MEM,  "ld_wb");

        // Store: 4 cycles
        step(1'b1, OP_ST, 1'b1, E_FETCH_G, "st_fetch");
        step(1'b1, OP_ST, 1'b1, E_DECODE,  "st_decode");
        step(1'b1, OP_ST, 1'b1, E_ADDR,    "st_addr");
        step(1'b1, OP_ST, 1'b1, E_MEM_ST,  "st_mem");

        // Branch: 3 cycles
        step(1'b1, OP_BR, 1'b1, E_FETCH_G, "br_fetch");
        step(1'b1, OP_BR, 1'b1, E_DECODE,  "br_decode");
        step(1'b1, OP_BR, 1'b1, E_BRANCH,  "br_branch");

        // mem_ready arriving on the limit cycle wins over the timeout
        step(1'b1, OP_R, 1'b0, E_FETCH_W, "lim_w1");
        step(1'b1, OP_R, 1'b0, E_FETCH_W, "lim_w2");
        step(1'b1, OP_R, 1'b0, E_FETCH_W, "lim_w3");
        step(1'b1, OP_R, 1'b1, E_FETCH_G, "lim_ready");
        step(1'b1, OP_R, 1'b1, E_DECODE,  "lim_decode");
        step(1'b1, OP_R, 1'b1, E_EXEC_R,  "lim_exec");
        step(1'b1, OP_R, 1'b1, E_WB_ALU,  "lim_wb");

        // Store abandoned by asynchronous reset mid-MEM
        step(1'b1, OP_ST, 1'b1, E_FETCH_G, "ar_fetch");
        step(1'b1, OP_ST, 1'b1, E_DECODE,  "ar_decode");
        step(1'b1, OP_ST, 1'b0, E_ADDR,    "ar_addr");
        step(1'b1, OP_ST, 1'b0, E_MEM_ST,  "ar_mem_w1");
        step(1'b1, OP_ST, 1'b0, E_MEM_ST,  "ar_mem_w2");
        @(posedge clk);
        #1;
        ent.name = "async_rst_drop"; ent.vec = E_RST;
        q.push_back(ent);
        #1;
        rst_n = 1'b0;
        #2;
        ent.name = "async_rst_hold"; ent.vec = E_RST;
        q.push_back(ent);
        // Counter must restart at 0: three waits then ready must not time out
        step(1'b1, OP_R, 1'b0, E_FETCH_W, "ar_w1");
        step(1'b1, OP_R, 1'b0, E_FETCH_W, "ar_w2");
        step(1'b1, OP_R, 1'b0, E_FETCH_W, "ar_w3");
        step(1'b1, OP_R, 1'b1, E_FETCH_G, "ar_ready");
        step(1'b1, OP_R, 1'b1, E_DECODE,  "ar_decode2");
        step(1'b1, OP_R, 1'b1, E_EXEC_R,  "ar_exec");
        step(1'b1, OP_R, 1'b1, E_WB_ALU,  "ar_wb");

        // Unlisted opcode
        step(1'b1, OP_IL, 1'b1, E_FETCH_G, "il_fetch");
        step(1'b1, OP_IL, 1'b1, E_DECODE,  "il_decode");
`ifdef ILLEGAL_TRAP_EN
        for (int i = 0; i < 3; i++) step(1'b1, OP_IL, 1'b1, E_HALT_I, "il_halt");
        step(1'b0, OP_R, 1'b1, E_RST, "il_reset");
`endif

        // Timeout in FETCH after 4 wait cycles, then HALT held 20 cycles
        step(1'b1, OP_R, 1'b0, E_FETCH_W, "to_w1");
        step(1'b1, OP_R, 1'b0, E_FETCH_W, "to_w2");
        step(1'b1, OP_R, 1'b0, E_FETCH_W, "to_w3");
        step(1'b1, OP_R, 1'b0, E_FETCH_W, "to_w4");
        for (int i = 0; i < 20; i++) step(1'b1, OP_R, 1'b1, E_HALT_F, "to_halt");
        check_now(E_HALT_F, "timeout_direct");
        step(1'b0, OP_R, 1'b1, E_RST, "to_reset");

        // Normal operation resumes after reset
        step(1'b1, OP_BR, 1'b1, E_FETCH_G, "post_fetch");
        step(1'b1, OP_BR, 1'b1, E_DECODE,  "post_decode");
        step(1'b1, OP_BR, 1'b1, E_BRANCH,  "post_branch");
        step(1'b1, OP_BR, 1'b0, E_FETCH_W, "post_wait");

        @(posedge clk);
        #10;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
